// File: rtl/link_out_arbiter.sv
// Round-robin sequencer that shares one byte-serial router link among NUM_REQ packet sources.
// Define LINK_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module link_out_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_pkt,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  input  logic                   free_outbound,
  output logic                   put_outbound,
  output logic [7:0]             payload_outbound
);

  typedef enum logic [1:0] {StIdle, StWaitFree, StSend} state_e;

  state_e           state_q;
  logic [31:0]      pkt_q;
  logic [1:0]       count_q;
  logic [PTR_W-1:0] start;
  logic             sel_valid;
  logic [PTR_W-1:0] sel_idx;
  logic [31:0]      sel_pkt;

`ifdef LINK_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] next_ptr;

  assign start    = ptr_q;
  assign next_ptr = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
`endif

  // Two passes give a wrapping search: indices at/above start first, then from 0.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_pkt   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!sel_valid && req[j] && (j >= int'(start))) begin
        sel_valid = 1'b1;
        sel_idx   = PTR_W'(j);
        sel_pkt   = req_pkt[32*j +: 32];
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!sel_valid && req[j]) begin
        sel_valid = 1'b1;
        sel_idx   = PTR_W'(j);
        sel_pkt   = req_pkt[32*j +: 32];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      grant            <= '0;
      busy             <= 1'b0;
      put_outbound     <= 1'b0;
      payload_outbound <= 8'h00;
      count_q          <= 2'd0;
      pkt_q            <= '0;
`ifndef LINK_ARB_FIXED_PRIO_EN
      ptr_q            <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          put_outbound <= 1'b0;
          if (sel_valid) begin
            pkt_q   <= sel_pkt;
            grant   <= NUM_REQ'(1) << sel_idx;
            busy    <= 1'b1;
            state_q <= StWaitFree;
`ifndef LINK_ARB_FIXED_PRIO_EN
            ptr_q   <= next_ptr;
`endif
          end else begin
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        StWaitFree: begin
          grant <= '0;
          if (free_outbound) begin
            put_outbound     <= 1'b1;
            payload_outbound <= pkt_q[31:24];
            count_q          <= 2'd1;
            state_q          <= StSend;
          end else begin
            put_outbound <= 1'b0;
          end
        end
        StSend: begin
          // Once started the packet is committed; free_outbound is not consulted.
          put_outbound <= 1'b1;
          count_q      <= count_q + 2'd1;
          case (count_q)
            2'd1:    payload_outbound <= pkt_q[23:16];
            2'd2:    payload_outbound <= pkt_q[15:8];
            default: begin
              payload_outbound <= pkt_q[7:0];
              state_q          <= StIdle;
            end
          endcase
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_link_out_arbiter.sv
// Self-checking bench for link_out_arbiter: directed scenarios plus random traffic against a
// transaction-level model (byte queue per granted packet). Honours LINK_ARB_FIXED_PRIO_EN.
module tb_link_out_arbiter;

  localparam int NUM_REQ = 4;

  logic                  clock;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_pkt;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic                  free_outbound;
  logic                  put_outbound;
  logic [7:0]            payload_outbound;

  link_out_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clock            (clock),
    .reset            (reset),
    .req              (req),
    .req_pkt          (req_pkt),
    .grant            (grant),
    .busy             (busy),
    .free_outbound    (free_outbound),
    .put_outbound     (put_outbound),
    .payload_outbound (payload_outbound)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: owns a packet while bytes remain in m_q.
  logic [NUM_REQ-1:0] m_grant;
  logic               m_busy;
  logic               m_put;
  logic [7:0]         m_payload;
  int                 m_ptr;
  bit                 m_active;
  bit                 m_started;
  logic [7:0]         m_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    int          winner;
    int          idx;
    logic [31:0] pkt;
    if (reset) begin
      m_grant = '0; m_busy = 1'b0; m_put = 1'b0; m_payload = 8'h00;
      m_ptr = 0; m_active = 0; m_started = 0;
      m_q.delete();
      return;
    end
    if (m_active && m_q.size() == 0) m_active = 0;
    if (m_active) begin
      m_grant = '0;
      if (m_started || free_outbound) begin
        m_put     = 1'b1;
        m_payload = m_q.pop_front();
        m_started = 1;
      end else begin
        m_put = 1'b0;
      end
    end else begin
      m_put  = 1'b0;
      winner = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef LINK_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (m_ptr + k) % NUM_REQ;
`endif
        if (winner < 0 && req[idx]) winner = idx;
      end
      if (winner >= 0) begin
        pkt = req_pkt[32*winner +: 32];
        m_q.delete();
        m_q.push_back(pkt[31:24]);
        m_q.push_back(pkt[23:16]);
        m_q.push_back(pkt[15:8]);
        m_q.push_back(pkt[7:0]);
        m_grant   = NUM_REQ'(1) << winner;
        m_busy    = 1'b1;
        m_ptr     = (winner + 1) % NUM_REQ;
        m_active  = 1;
        m_started = 0;
      end else begin
        m_grant = '0;
        m_busy  = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    cyc++;
    check_eq("grant", 32'(grant), 32'(m_grant));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("put", 32'(put_outbound), 32'(m_put));
    if (m_put) check_eq("payload", 32'(payload_outbound), 32'(m_payload));
  endtask

  task automatic set_pkt(input int i, input logic [31:0] v);
    req_pkt[32*i +: 32] = v;
  endtask

  int last_grant_cyc;
  int ngrants;

  initial begin
    reset = 1'b1; req = '0; req_pkt = '0; free_outbound = 1'b0;
    m_grant = '0; m_busy = 0; m_put = 0; m_payload = 0; m_ptr = 0;
    step();
    step();
    check_eq("reset_payload", 32'(payload_outbound), 32'h00);
    reset = 1'b0;
    step();

    // Single request from requester 1.
    req = 4'b0010; set_pkt(1, 32'h12A5B6C7); free_outbound = 1'b1;
    step();
    check_eq("single_grant", 32'(grant), 32'h2);
    req = '0;
    for (int i = 0; i < 7; i++) step();

    // Fairness: all requesting, grants must be exactly 5 cycles apart.
    req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_pkt(i, 32'hA0B0C0D0 + 32'(i));
    last_grant_cyc = -1; ngrants = 0;
    for (int i = 0; i < 22; i++) begin
      step();
      if (grant != '0) begin
        if (last_grant_cyc >= 0) check_eq("grant_spacing", 32'(cyc - last_grant_cyc), 32'd5);
        last_grant_cyc = cyc;
        ngrants++;
      end
    end
    check_eq("fair_grant_count", 32'(ngrants), 32'd5);
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // Wait for free with requester 2; free drops mid-send.
    req = 4'b0100; set_pkt(2, 32'h5A6B7C8D); free_outbound = 1'b0;
    step();
    req = '0;
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("wait_busy", 32'(busy), 32'd1);
    end
    free_outbound = 1'b1;
    step();
    check_eq("first_byte_after_free", 32'(payload_outbound), 32'h5A);
    free_outbound = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Wrap and skip: pointer now at 3 in round-robin mode.
    req = 4'b0101; set_pkt(0, 32'h01020304); set_pkt(2, 32'h05060708); free_outbound = 1'b1;
    for (int i = 0; i < 12; i++) step();
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // Reset after the second byte.
    req = 4'b0001; set_pkt(0, 32'hDEADBEEF);
    step();
    req = '0;
    step();
    step();
    reset = 1'b1;
    step();
    check_eq("reset_mid_put", 32'(put_outbound), 32'd0);
    reset = 1'b0; req = 4'b1000; set_pkt(3, 32'h33445566);
    step();
    check_eq("post_reset_grant", 32'(grant), 32'h8);
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // Packet is sampled only at the grant edge.
    req = 4'b0001; set_pkt(0, 32'h11111111);
    step();
    req = '0; set_pkt(0, 32'h22222222);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("sample_once", 32'(payload_outbound), 32'h11);
    end
    for (int i = 0; i < 3; i++) step();

    // Random traffic with random packets changing every cycle.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      req           = NUM_REQ'($urandom) & NUM_REQ'($urandom);
      free_outbound = ($urandom_range(0, 9) < 7);
      for (int r = 0; r < NUM_REQ; r++) set_pkt(r, $urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/link_out_arbiter.md
Name: link_out_arbiter

Overview:
- Shares one byte-serial router link among NUM_REQ packet sources (node queues or router input buffers).
- Each cycle with no transfer in flight, it grants one requester round-robin and captures that requester's 32-bit packet.
- It waits for the downstream free signal, then drives the packet as four consecutive bytes on put/payload.
- It is the sequencer sitting between packet FIFOs and a router port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PTR_W, $clog2(NUM_REQ), width of the round-robin pointer (derived; do not override).

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  req[i]=1: requester i holds a valid packet.
- req_pkt  input  32*NUM_REQ  packet of requester i on bits [32*i+31:32*i]; bits [31:24] = {src,dest}, [23:0] = data.
- grant  output  NUM_REQ  one-hot, one-cycle pulse; requester i must dequeue its packet in that cycle.
- busy  output  1  high from the grant cycle through the last byte cycle.
- free_outbound  input  1  downstream is able to accept a packet.
- put_outbound  output  1  payload_outbound carries a valid byte this cycle.
- payload_outbound  output  8  outbound byte.

Behaviour:
- Reset values (any edge with reset=1, including mid-transfer):
  - grant=0, busy=0, put_outbound=0, payload_outbound=8'h00.
  - Round-robin pointer=0, byte count=0, state=IDLE.
  - A partially sent packet is abandoned; no further bytes are driven.
- State machine: IDLE, WAIT_FREE, SEND.
- IDLE:
  - Edge with req!=0: select the first i with req[i]=1, searching from pointer upward with wrap (NUM_REQ-1 -> 0).
  - Latch req_pkt slice i; grant<=onehot(i); busy<=1; pointer<=(i+1) mod NUM_REQ; state<=WAIT_FREE.
  - Edge with req==0: hold state; grant<=0, busy<=0.
  - put_outbound<=0 on every IDLE edge.
- WAIT_FREE:
  - grant<=0 (pulse is exactly one cycle).
  - Edge with free_outbound=1: put_outbound<=1, payload_outbound<=pkt[31:24], count<=1, state<=SEND.
  - Edge with free_outbound=0: remain in WAIT_FREE, put_outbound<=0. No timeout.
- SEND:
  - Each edge: put_outbound<=1, payload_outbound<=byte[count], count++.
  - Byte order: count 1 = pkt[23:16], count 2 = pkt[15:8], count 3 = pkt[7:0].
  - After driving count 3: state<=IDLE, busy<=0 on the following IDLE edge.
  - free_outbound is ignored during SEND. put_outbound is high for exactly 4 consecutive cycles per packet.
- Latency and throughput:
  - Req visible at edge E0 -> grant high E0..E1.
  - With free_outbound already high: first byte at E1..E2, last byte at E4..E5.
  - Next grant is evaluated at E5, so the minimum packet-to-packet spacing is 5 cycles.
- Ownership:
  - Requests arriving while busy are not granted until IDLE.
  - A requester deasserting req before being granted is simply skipped.
  - req_pkt is sampled only at the grant edge; later changes do not affect the transfer.
- Pointer arithmetic wraps modulo NUM_REQ; the pointer is unchanged when nothing is granted.

Optional Feature:
- Macro: LINK_ARB_FIXED_PRIO_EN.
- Defined: round-robin disabled. The lowest index with req=1 always wins, and the pointer register is not implemented (or is held at 0).
- Undefined (default): round-robin arbitration as above.

Test Plan:
- Single request: req=4'b0010, req_pkt[1]=32'h12A5B6C7, free_outbound=1.
  - Required: grant=4'b0010 for 1 cycle.
  - Then put_outbound=1 for 4 cycles with payload 8'h12, 8'hA5, 8'hB6, 8'hC7, then put_outbound=0 and busy=0.
- Round-robin fairness: req=4'b1111 held for 4 packets, free_outbound=1.
  - Required: grant order 0,1,2,3, then 0 again; grants are exactly 5 cycles apart.
- Wait for free: grant to req 2 with free_outbound=0 for 7 cycles.
  - Required: put_outbound stays 0 and busy stays 1; the first byte appears the cycle after free_outbound rises.
  - Dropping free_outbound during SEND does not stall the remaining bytes.
- Wrap and skip: pointer=3 with req=4'b0101.
  - Required: grant to 0, then to 2.
  - With LINK_ARB_FIXED_PRIO_EN defined, the same stimulus with req held grants 0 repeatedly.
- Reset mid-operation: assert reset after the 2nd byte.
  - Required: put_outbound=0, grant=0, busy=0 from the next cycle, and no further bytes.
  - After release with req=4'b1000, the first grant is to 3 (pointer restarted at 0).
- Sample-once: change req_pkt[0] from 32'h11111111 to 32'h22222222 the cycle after grant.
  - Required: payload bytes are all 8'h11.
